// File: rtl/pi1_dma_if.sv
// pi1_dma_if: pi1 request/response bus between a master and the interconnect.
interface pi1_dma_if #(
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
);
  logic [1:0]             op;
  logic [ADDRBITSZ-1:0]   addr;
  logic [ARCHBITSZ-1:0]   wdata;
  logic [ARCHBITSZ-1:0]   rdata;
  logic [ARCHBITSZ/8-1:0] sel;
  logic                   rdy;

  modport master (
    output op, addr, wdata, sel,
    input  rdata, rdy
  );

  modport slave (
    input  op, addr, wdata, sel,
    output rdata, rdy
  );
endinterface

// File: rtl/pi1_dma.sv
// pi1_dma: pi1 master copying a block of words between word addresses.
// Define PI1DMA_FILL_EN to add a pattern-fill mode (fill_i, pattern_i).
module pi1_dma #(
  parameter int ARCHBITSZ = 32,
  parameter int LENBITSZ  = 16,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDRBITSZ-1:0] src_i,
  input  logic [ADDRBITSZ-1:0] dst_i,
  input  logic [LENBITSZ-1:0]  len_i,
`ifdef PI1DMA_FILL_EN
  input  logic                 fill_i,
  input  logic [ARCHBITSZ-1:0] pattern_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  pi1_dma_if.master            pi1
);

  localparam logic [1:0] OP_NOOP = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_RD   = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RDREQ,
    RDWAIT,
    WRREQ,
    WRWAIT,
    DONE
  } state_t;

  state_t               state;
  logic [1:0]           op;
  logic [ADDRBITSZ-1:0] addr;
  logic [ADDRBITSZ-1:0] src;
  logic [ADDRBITSZ-1:0] dst;
  logic [LENBITSZ-1:0]  cnt;
  logic [ARCHBITSZ-1:0] buff;
`ifdef PI1DMA_FILL_EN
  logic                 fill;
`endif

  // Carry out of the increment is dropped: addresses wrap.
  logic [ADDRBITSZ-1:0] src_nxt;
  logic [ADDRBITSZ-1:0] dst_nxt;
  assign src_nxt = src + ADDRBITSZ'(1);
  assign dst_nxt = dst + ADDRBITSZ'(1);

  assign pi1.op    = op;
  assign pi1.addr  = addr;
  assign pi1.wdata = buff;
  assign pi1.sel   = '1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      op     <= OP_NOOP;
      addr   <= '0;
      src    <= '0;
      dst    <= '0;
      cnt    <= '0;
      buff   <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
`ifdef PI1DMA_FILL_EN
      fill   <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              src    <= src_i;
              dst    <= dst_i;
              cnt    <= len_i;
              busy_o <= 1'b1;
`ifdef PI1DMA_FILL_EN
              fill   <= fill_i;
              if (fill_i) begin
                buff  <= pattern_i;
                state <= WRREQ;
                op    <= OP_WR;
                addr  <= dst_i;
              end else begin
                state <= RDREQ;
                op    <= OP_RD;
                addr  <= src_i;
              end
`else
              state  <= RDREQ;
              op     <= OP_RD;
              addr   <= src_i;
`endif
            end
          end
        end
        RDREQ: begin
          if (pi1.rdy) begin
            state <= RDWAIT;
            op    <= OP_NOOP;
          end
        end
        RDWAIT: begin
          if (pi1.rdy) begin
            buff  <= pi1.rdata;
            state <= WRREQ;
            op    <= OP_WR;
            addr  <= dst;
          end
        end
        WRREQ: begin
          if (pi1.rdy) begin
            state <= WRWAIT;
            op    <= OP_NOOP;
          end
        end
        WRWAIT: begin
          if (pi1.rdy) begin
            src <= src_nxt;
            dst <= dst_nxt;
            cnt <= cnt - LENBITSZ'(1);
            if (cnt == LENBITSZ'(1)) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
`ifdef PI1DMA_FILL_EN
            end else if (fill) begin
              state <= WRREQ;
              op    <= OP_WR;
              addr  <= dst_nxt;
`endif
            end else begin
              state <= RDREQ;
              op    <= OP_RD;
              addr  <= src_nxt;
            end
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef PI1DMA_FILL_EN
          fill  <= 1'b0;
`endif
        end
        default: begin
          state  <= IDLE;
          op     <= OP_NOOP;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
